bch_encoder: RTL
================

Name: bch_encoder

Overview:
- Systematic binary BCH(63,51) encoder, t=2, over GF(2^6) with field polynomial x^6+x+1.
- Sits in the transmit path directly upstream of the channel and receive-side BCH decoder.
- Takes a serial bit stream with valid/ready handshake. Forwards each 51-bit message block unchanged, then appends 12 parity bits, giving a 63-bit codeword stream.
- Bit order: the bit at stream index t (0..62, first bit t=0) is the coefficient of x^t of c(x). Every emitted codeword satisfies c(α)=c(α^3)=0, where α is a root of x^6+x+1.

Parameters:
- None. The code is fixed: N=63, K=51, 12 parity bits, generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream bit valid
- in_data  in  1  message bit
- in_ready  out  1  encoder accepts in_data this cycle
- out_valid  out  1  out_data holds a codeword bit
- out_data  out  1  codeword bit, stream order
- out_ready  in  1  downstream accepts out_data this cycle

Behaviour:
- Reset: rst_n=0 asynchronously forces the following, independent of clk. Once rst_n is released the block waits for the first message bit.
  - state=ST_MSG, bit counter cnt=0, 12-bit LFSR=0
  - out_valid=0, out_data=0
- Output register: a single register stage holds out_data/out_valid.
  - free = !out_valid | out_ready.
  - A bit held with out_valid=1 and out_ready=0 stays stable until it is taken.
  - If nothing new is loaded and out_ready=1, out_valid falls to 0.
- in_ready = (state==ST_MSG) & free. It is purely combinational from registers and out_ready; there is no in_valid→in_ready path.
- ST_MSG (message pass-through), on accept (in_valid & in_ready):
  - out_data<=in_data, out_valid<=1, cnt<=cnt+1.
  - fb = in_data ^ LFSR[11].
  - LFSR <= {LFSR[10:0],1'b0} ^ (fb ? 12'h395 : 0). 12'h395 holds the low terms of the reciprocal generator g*(x)=x^12+x^9+x^8+x^7+x^4+x^2+1.
  - After the accept with cnt==50: cnt<=0 and state<=ST_PARITY.
- ST_PARITY (parity emission), each cycle with free=1:
  - out_data<=LFSR[11], out_valid<=1, LFSR<={LFSR[10:0],1'b0}, cnt<=cnt+1.
  - After the emit with cnt==11: cnt<=0, LFSR<=0, state<=ST_MSG.
  - in_ready=0 throughout ST_PARITY. in_valid is ignored and upstream data is not consumed.
- Latency: each output bit appears on out_data 1 cycle after its accept or emit.
- Throughput: with in_valid=out_ready=1 continuously, the block emits 63 bits in 63 consecutive cycles per frame. in_ready is low for 12 of every 63 cycles.
- Back-to-back frames: the first message bit of frame n+1 can be accepted in the cycle after the last parity load of frame n, with no bubble.
- Backpressure: out_ready=0 freezes the LFSR, cnt and state because free=0. No bit is dropped or duplicated.
- Upstream stall: in_valid=0 in ST_MSG freezes LFSR and cnt. Partial frames are held indefinitely.
- Reset mid-frame: the partial codeword is discarded and the next accepted bit is stream index t=0 of a new frame.
- No bit-count overflow: cnt is 6 bits and never exceeds 50.

Test Plan:
- All-zero message: 51 zeros, out_ready=1 → 63 zeros out, with in_ready low for exactly 12 cycles after bit 51 is accepted.
- All-ones message: 51 ones → 63 ones out, since the all-ones word is a codeword. Parity bits 51..62 are all 1.
- Random messages (≥1000 frames): each 63-bit output equals the message in bits 0..50, and the model syndromes S1=Σc_t·α^t and S3=Σc_t·α^(3t) are both 0. Loop the output through the receive-side decoder with 0, 1 and 2 injected bit flips → original message recovered.
- Random backpressure: toggle out_ready and in_valid at random (~50%) → output identical to the no-stall run. out_data is stable while out_valid & !out_ready. in_ready is never 1 in ST_PARITY.
- Reset mid-frame: assert rst_n=0 after 30 message bits (async, between edges) → out_valid=0 immediately. The next frame of 51 zeros produces 63 zeros.
- Back-to-back frames with in_valid=out_ready=1 → 3 frames in exactly 189 output cycles, no gaps.

Source files
------------

// File: rtl/bch_encoder.sv
// Systematic BCH(63,51) t=2 serial encoder over GF(2^6), field polynomial x^6+x+1.
// Message bits pass straight through; the 12 parity bits follow, giving a
// 63-bit codeword whose stream index t is the coefficient of x^t.
module bch_encoder (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready
);

  localparam int unsigned K      = 51;
  localparam int unsigned P      = 12;
  localparam int unsigned CNT_W  = 6;
  // Low terms of the reciprocal generator g*(x)=x^12+x^9+x^8+x^7+x^4+x^2+1.
  // The stream carries the lowest-degree coefficient first, so dividing by
  // g*(x) in a conventional MSB-first LFSR yields multiples of g(x).
  localparam logic [P-1:0] GEN_REV = 12'h395;

  typedef enum logic {
    ST_MSG,
    ST_PARITY
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [P-1:0]     lfsr;
  logic [P-1:0]     lfsr_nxt;
  logic             out_valid_nxt;
  logic             out_data_nxt;
  logic             free;
  logic             fb;

  // Output stage can take a new bit when empty or being drained this cycle.
  always_comb begin
    free     = !out_valid | out_ready;
    in_ready = (state == ST_MSG) & free;
  end

  // State, counter, LFSR and output register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_MSG;
      cnt       <= '0;
      lfsr      <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lfsr      <= lfsr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Next-state logic: pass message bits through while dividing, then shift out remainder.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lfsr_nxt      = lfsr;
    out_valid_nxt = out_valid & !out_ready;
    out_data_nxt  = out_data;
    fb            = in_data ^ lfsr[P-1];

    case (state)
      ST_MSG: begin
        if (in_valid && free) begin
          out_data_nxt  = in_data;
          out_valid_nxt = 1'b1;
          lfsr_nxt      = {lfsr[P-2:0], 1'b0} ^ (fb ? GEN_REV : {P{1'b0}});
          if (cnt == CNT_W'(K - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_PARITY;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (free) begin
          out_data_nxt  = lfsr[P-1];
          out_valid_nxt = 1'b1;
          lfsr_nxt      = {lfsr[P-2:0], 1'b0};
          if (cnt == CNT_W'(P - 1)) begin
            cnt_nxt   = '0;
            lfsr_nxt  = '0;
            state_nxt = ST_MSG;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

endmodule
